pipelined_carry_skip_adder: RTL and testbench



---
 rtl/arith_pkg.sv | 16 +
 rtl/csa_skip_block.sv | 29 ++
 rtl/pipelined_carry_skip_adder.sv | 127 ++++++++++++
 tb/tb_pipelined_carry_skip_adder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: skip-block count derivation and
// the per-stage control register layout of the pipelined carry-skip adder.
package arith_pkg;

    // Operand-width fields (partial sum, remaining a/b_eff) depend on WIDTH,
    // so they live beside this record in the instantiating module.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int unsigned nblk(input int unsigned width, input int unsigned block);
        return width / block;
    endfunction

endpackage

// File: rtl/csa_skip_block.sv
// One carry-skip block: BLOCK-bit ripple adder whose carry-out bypasses the
// ripple chain when every bit position propagates.
module csa_skip_block #(
    parameter int unsigned BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout,
    output logic             prop
);

    logic [BLOCK-1:0] p;
    logic             rc;

    always_comb begin
        p   = a ^ b;
        sum = '0;
        rc  = cin;
        for (int unsigned i = 0; i < BLOCK; i++) begin
            sum[i] = p[i] ^ rc;
            rc     = (a[i] & b[i]) | (rc & p[i]);
        end
        prop = &p;
        cout = prop ? cin : rc;
    end

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder/subtractor: one skip block per pipeline stage,
// valid/ready handshake on both sides with a single global advance.
module pipelined_carry_skip_adder
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NBLK = nblk(WIDTH, BLOCK);
    localparam int unsigned LAST = NBLK - 1;

    if (BLOCK == 0 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
        $error("pipelined_carry_skip_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             adv;

    logic [BLOCK-1:0] blk_a  [NBLK];
    logic [BLOCK-1:0] blk_b  [NBLK];
    logic [BLOCK-1:0] blk_s  [NBLK];
    logic             blk_ci [NBLK];
    logic             blk_co [NBLK];
    logic             blk_p  [NBLK];

    stage_ctl_t       ctl_q   [NBLK];
    logic [WIDTH-1:0] sum_q   [NBLK];
    logic [WIDTH-1:0] a_q     [NBLK];
    logic [WIDTH-1:0] b_q     [NBLK];
    logic [WIDTH-1:0] sum_nxt [NBLK];

    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | cin;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 0 reads the conditioned inputs; later stages read the operand
    // bits carried forward by the previous stage register.
    always_comb begin
        blk_a[0]  = a[0 +: BLOCK];
        blk_b[0]  = b_eff[0 +: BLOCK];
        blk_ci[0] = c0;
        for (int unsigned k = 1; k < NBLK; k++) begin
            blk_a[k]  = a_q[k-1][k*BLOCK +: BLOCK];
            blk_b[k]  = b_q[k-1][k*BLOCK +: BLOCK];
            blk_ci[k] = ctl_q[k-1].carry;
        end
    end

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        csa_skip_block #(
            .BLOCK(BLOCK)
        ) u_blk (
            .a   (blk_a[k]),
            .b   (blk_b[k]),
            .cin (blk_ci[k]),
            .sum (blk_s[k]),
            .cout(blk_co[k]),
            .prop(blk_p[k])
        );
    end

    always_comb begin
        sum_nxt[0]              = '0;
        sum_nxt[0][0 +: BLOCK]  = blk_s[0];
        for (int unsigned k = 1; k < NBLK; k++) begin
            sum_nxt[k]                  = sum_q[k-1];
            sum_nxt[k][k*BLOCK +: BLOCK] = blk_s[k];
        end
    end

    // A fully propagating block must hand its carry-in straight through.
    always_comb begin
        for (int unsigned k = 0; k < NBLK; k++) begin
            if (blk_p[k]) begin
                assert (blk_co[k] == blk_ci[k]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NBLK; k++) begin
                ctl_q[k] <= '0;
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else if (adv) begin
            ctl_q[0].valid <= in_valid;
            ctl_q[0].carry <= blk_co[0];
            sum_q[0]       <= sum_nxt[0];
            a_q[0]         <= a;
            b_q[0]         <= b_eff;
            for (int unsigned k = 1; k < NBLK; k++) begin
                ctl_q[k].valid <= ctl_q[k-1].valid;
                ctl_q[k].carry <= blk_co[k];
                sum_q[k]       <= sum_nxt[k];
                a_q[k]         <= a_q[k-1];
                b_q[k]         <= b_q[k-1];
            end
        end
    end

    assign out_valid = ctl_q[LAST].valid;
    assign sum       = sum_q[LAST];
    assign cout      = ctl_q[LAST].carry;
    assign ovf       = ctl_q[LAST].carry
                     ^ (a_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1] ^ sum_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Directed self-checking bench for pipelined_carry_skip_adder (WIDTH=16, BLOCK=4).
module tb_pipelined_carry_skip_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    pipelined_carry_skip_adder #(
        .WIDTH(16),
        .BLOCK(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single transaction into an empty pipeline with out_ready held high.
    task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic tcin, input logic tsub,
                           input logic [15:0] esum, input logic ecout, input logic eovf);
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = ~tcin; sub = ~tsub;
        repeat (2) @(posedge clk);
        #1 check({tag, "_early"}, out_valid, 0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sum"}, sum, esum);
        check({tag, "_cout"}, cout, ecout);
        check({tag, "_ovf"}, ovf, eovf);
        @(posedge clk);
        #1 check({tag, "_drain"}, out_valid, 0);
    endtask

    logic [15:0] va   [8] = '{16'h0001, 16'hA5A5, 16'hFFFF, 16'h8000, 16'h1000, 16'h0000, 16'h1234, 16'h7FFF};
    logic [15:0] vb   [8] = '{16'h0002, 16'h5A5A, 16'hFFFF, 16'h8000, 16'h0001, 16'h0001, 16'h0F0F, 16'hFFFF};
    logic        vcin [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        vsub [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] esum [8] = '{16'h0003, 16'hFFFF, 16'hFFFE, 16'h0000, 16'h0FFF, 16'hFFFF, 16'h2144, 16'h8000};
    logic        ecy  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        eov  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int          idx_in;
        int          idx_out;
        logic [15:0] hold_sum;
        logic        hold_cout;
        logic        hold_ovf;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_in_ready", in_ready, 1);

        run_one("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_one("skip_all",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one("sub_borrow",16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_one("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_one("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one("wrap",      16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one("sub_cin_ig",16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0);

        // Back-to-back stream of 8 with a 5-cycle downstream stall (cycles 6..10).
        idx_in = 0; idx_out = 0;
        hold_sum = '0; hold_cout = 1'b0; hold_ovf = 1'b0;
        for (int cyc = 0; cyc < 40 && idx_out < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 10);
            in_valid  = (idx_in < 8);
            if (idx_in < 8) begin
                a = va[idx_in]; b = vb[idx_in]; cin = vcin[idx_in]; sub = vsub[idx_in];
            end
            #1;
            if (cyc == 6) begin
                hold_sum = sum; hold_cout = cout; hold_ovf = ovf;
                check("stall_out_valid", out_valid, 1);
            end
            if (cyc > 6 && cyc <= 10) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_sum", sum, hold_sum);
                check("stall_cout", cout, hold_cout);
                check("stall_ovf", ovf, hold_ovf);
            end
            if (out_valid && out_ready) begin
                check($sformatf("stream%0d_sum", idx_out), sum, esum[idx_out]);
                check($sformatf("stream%0d_cout", idx_out), cout, ecy[idx_out]);
                check($sformatf("stream%0d_ovf", idx_out), ovf, eov[idx_out]);
                idx_out++;
            end
            if (in_valid && in_ready) idx_in++;
        end
        check("stream_count", idx_out, 8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("stream_drained", out_valid, 0);

        // Four accepted: the first reaches the output, three remain in flight.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = 16'h0100 + 16'(i); b = 16'h0011; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_sum", sum, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 check($sformatf("post_rst_idle%0d", i), out_valid, 0);
        end
        run_one("post_rst", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
